// File: rtl/keypad_pkg.sv
// Shared constants and types for the memory-mapped 4x4 keypad responder.
package keypad_pkg;

  localparam int unsigned STATUS_OFS = 0;
  localparam int unsigned DATA_OFS   = 4;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_OVERFLOW  = 1;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_IRQ_EN    = 8;

  localparam int CTRL_POP     = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam logic [31:0] EMPTY_READ = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DB_IDLE      = 2'd0,
    DB_CANDIDATE = 2'd1,
    DB_PRESSED   = 2'd2
  } db_state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Small synchronous key-code FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module keypad_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic [W-1:0]  o_head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | i_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/keypad_responder.sv
// 4x4 keypad bus responder: row scanner, debounce FSM and STATUS/DATA/CTRL
// registers. Optional interrupt output enabled by defining KEYPAD_IRQ_EN.
module keypad_responder
  import keypad_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'hFFFF_0010,
  parameter int          SCAN_DIV       = 50000,
  parameter int          DEBOUNCE_SCANS = 4,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addressVirt,
  input  logic [31:0] dataInVirt,
  input  logic        wEnVirt,
  output logic [31:0] dataOutVirt,
  output logic        selVirt,
  output logic [3:0]  rows,
  input  logic [3:0]  cols
`ifdef KEYPAD_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int SW   = $clog2(DEBOUNCE_SCANS + 1);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  logic [3:0]      r_cols_meta;
  logic [3:0]      r_cols_sync;
  logic [DIVW-1:0] r_div;
  logic [1:0]      r_row;
  logic [11:0]     r_image;
  db_state_t       r_state;
  logic [3:0]      r_cand;
  logic [SW-1:0]   r_stable;
  logic            r_ovf;

  logic            w_sample;
  logic            w_scan_done;
  logic [15:0]     w_image_full;
  logic [4:0]      w_nkeys;
  logic [3:0]      w_code;
  db_state_t       w_state_nxt;
  logic [3:0]      w_cand_nxt;
  logic [SW-1:0]   w_stable_nxt;
  logic            w_push;
  logic [3:0]      w_push_code;
  logic            w_sel;
  logic            w_wr;
  logic            w_pop;
  logic            w_clr;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [3:0]      w_head;
  logic [31:0]     w_status;
  logic [31:0]     w_data;
  logic            w_unused;

  assign w_unused = &{1'b0, dataInVirt[31:3], dataInVirt[2], addressVirt[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cols_meta <= 4'hF;
      r_cols_sync <= 4'hF;
    end else begin
      r_cols_meta <= cols;
      r_cols_sync <= r_cols_meta;
    end
  end

  assign rows         = ~(4'b0001 << r_row);
  assign w_sample     = (r_div == DIVW'(SCAN_DIV - 1));
  assign w_scan_done  = w_sample & (r_row == 2'd3);
  // Row 3 is classified straight from the synchronizer on its sample cycle.
  assign w_image_full = {~r_cols_sync, r_image};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div   <= '0;
      r_row   <= '0;
      r_image <= '0;
    end else if (w_sample) begin
      r_div <= '0;
      r_row <= r_row + 2'd1;
      case (r_row)
        2'd0:    r_image[3:0]  <= ~r_cols_sync;
        2'd1:    r_image[7:4]  <= ~r_cols_sync;
        2'd2:    r_image[11:8] <= ~r_cols_sync;
        default: ;
      endcase
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_nkeys = popcount16(w_image_full);

  // Image bit index r*4+c is the key code itself.
  always_comb begin
    w_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_image_full[i]) w_code = 4'(i);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_stable_nxt = r_stable;
    w_push       = 1'b0;
    w_push_code  = r_cand;
    if (w_scan_done) begin
      case (r_state)
        DB_IDLE: begin
          if (w_nkeys == 5'd1) begin
            w_cand_nxt = w_code;
            if (DEBOUNCE_SCANS == 1) begin
              w_push      = 1'b1;
              w_push_code = w_code;
              w_state_nxt = DB_PRESSED;
            end else begin
              w_stable_nxt = SW'(1);
              w_state_nxt  = DB_CANDIDATE;
            end
          end
        end
        DB_CANDIDATE: begin
          if (w_nkeys != 5'd1) begin
            w_state_nxt = DB_IDLE;
          end else if (w_code != r_cand) begin
            w_cand_nxt   = w_code;
            w_stable_nxt = SW'(1);
          end else if (r_stable == SW'(DEBOUNCE_SCANS - 1)) begin
            w_push      = 1'b1;
            w_state_nxt = DB_PRESSED;
          end else begin
            w_stable_nxt = r_stable + 1'b1;
          end
        end
        DB_PRESSED: begin
          if (w_nkeys == 5'd0) w_state_nxt = DB_IDLE;
        end
        default: w_state_nxt = DB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= DB_IDLE;
      r_cand   <= '0;
      r_stable <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cand   <= w_cand_nxt;
      r_stable <= w_stable_nxt;
    end
  end

  assign w_sel = (addressVirt[31:3] == BASE_ADDR[31:3]);
  assign w_wr  = wEnVirt & w_sel & (addressVirt[2] == DATA_OFS[2]);
  assign w_pop = w_wr & dataInVirt[CTRL_POP];
  assign w_clr = w_wr & dataInVirt[CTRL_CLR_OVF];

  keypad_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (4),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_code),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // A clear in the same cycle as a dropped push leaves overflow set.
  always_ff @(posedge clk) begin
    if (!rst) r_ovf <= 1'b0;
    else      r_ovf <= (r_ovf & ~w_clr) | (w_push & w_full & ~w_pop);
  end

`ifdef KEYPAD_IRQ_EN
  logic r_irq_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_irq_en <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (w_wr) r_irq_en <= dataInVirt[CTRL_IRQ_EN];
      irq <= r_irq_en & ~w_empty;
    end
  end
`endif

  always_comb begin
    w_status                         = '0;
    w_status[ST_NOT_EMPTY]           = ~w_empty;
    w_status[ST_OVERFLOW]            = r_ovf;
    w_status[ST_COUNT_LSB +: 4]      = 4'(w_count);
`ifdef KEYPAD_IRQ_EN
    w_status[ST_IRQ_EN]              = r_irq_en;
`endif
  end

  assign w_data      = w_empty ? EMPTY_READ : {28'b0, w_head};
  assign selVirt     = w_sel;
  assign dataOutVirt = !w_sel ? 32'b0 : (addressVirt[2] ? w_data : w_status);

endmodule

// File: tb/tb_keypad_responder.sv
// Scoreboard bench for keypad_responder: driver tasks queue expected values,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_keypad_responder;

  localparam logic [31:0] BASE = 32'hFFFF_0010;
  localparam logic [31:0] CTRL = 32'hFFFF_0014;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addressVirt;
  logic [31:0] dataInVirt;
  logic        wEnVirt;
  logic [31:0] dataOutVirt;
  logic        selVirt;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        irq_w;
  logic [15:0] keys;

  logic [31:0] exp_q [$];
  logic [1:0]  kind_q [$];
  string       name_q [$];
  logic        chk_vld = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  keypad_responder #(
    .BASE_ADDR      (BASE),
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addressVirt (addressVirt),
    .dataInVirt  (dataInVirt),
    .wEnVirt     (wEnVirt),
    .dataOutVirt (dataOutVirt),
    .selVirt     (selVirt),
    .rows        (rows),
    .cols        (cols)
`ifdef KEYPAD_IRQ_EN
    ,
    .irq         (irq_w)
`endif
  );

`ifndef KEYPAD_IRQ_EN
  assign irq_w = 1'b0;
`endif

  // Keypad matrix model: a pressed key pulls its column low while its row is driven.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && keys[r*4+c]) cols[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (chk_vld) begin
      logic [31:0] e;
      logic [31:0] act;
      logic [1:0]  k;
      string       n;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: check presented with empty expected queue");
      end else begin
        e = exp_q.pop_front();
        k = kind_q.pop_front();
        n = name_q.pop_front();
        case (k)
          2'd0:    act = dataOutVirt;
          2'd1:    act = {31'b0, selVirt};
          2'd2:    act = {28'b0, rows};
          default: act = {31'b0, irq_w};
        endcase
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, e);
        end
      end
    end
  end

  task automatic expect_chk(input logic [1:0] kind, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    kind_q.push_back(kind);
    name_q.push_back(name);
    chk_vld = 1'b1;
    @(posedge clk);
    #1 chk_vld = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    addressVirt = addr;
    expect_chk(2'd0, exp, name);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    addressVirt = addr;
    dataInVirt  = data;
    wEnVirt     = 1'b1;
    @(posedge clk);
    #1 wEnVirt  = 1'b0;
    dataInVirt  = '0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tap_key(input int code);
    keys = 16'(1) << code;
    wait_cyc(64);
    keys = '0;
    wait_cyc(40);
  endtask

  initial begin
    logic [31:0] ovf_exp [5];
    int          ovf_codes [5];
    ovf_exp   = '{32'h11, 32'h21, 32'h31, 32'h41, 32'h43};
    ovf_codes = '{1, 2, 4, 7, 8};
    keys        = '0;
    addressVirt = BASE;
    dataInVirt  = '0;
    wEnVirt     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    expect_chk(2'd2, 32'hE, "reset_rows");
    rd(BASE, 32'h0, "reset_status");
    rd(CTRL, 32'hFFFF_FFFF, "reset_data");

    keys = 16'(1) << 6;
    wait_cyc(64);
    rd(BASE, 32'h11, "key6_status");
    rd(CTRL, 32'h6, "key6_data");
    wait_cyc(64);
    rd(BASE, 32'h11, "key6_held_no_repeat");
    keys = '0;
    wait_cyc(40);
    wr(CTRL, 32'h1);
    rd(BASE, 32'h0, "key6_popped");

    keys = 16'(1) << 3;
    wait_cyc(10);
    keys = '0;
    wait_cyc(64);
    rd(BASE, 32'h0, "glitch_status");
    rd(CTRL, 32'hFFFF_FFFF, "glitch_data");

    keys = (16'(1) << 0) | (16'(1) << 5);
    wait_cyc(64);
    rd(BASE, 32'h0, "multi_status");
    keys = '0;
    wait_cyc(40);
    keys = 16'(1) << 9;
    wait_cyc(64);
    rd(BASE, 32'h11, "key9_status");
    rd(CTRL, 32'h9, "key9_data");
    keys = '0;
    wait_cyc(40);
    wr(CTRL, 32'h1);

    for (int i = 0; i < 5; i++) begin
      tap_key(ovf_codes[i]);
      rd(BASE, ovf_exp[i], $sformatf("fill_status_%0d", i));
    end
    rd(CTRL, 32'h1, "ovf_head");
    wr(CTRL, 32'h3);
    rd(BASE, 32'h31, "pop_clr_status");
    rd(CTRL, 32'h2, "pop_clr_head");
    wr(BASE, 32'h3);
    rd(BASE, 32'h31, "status_write_ignored");
    wr(CTRL, 32'h1);
    rd(CTRL, 32'h4, "drain_head_4");
    wr(CTRL, 32'h1);
    rd(CTRL, 32'h7, "drain_head_7");
    wr(CTRL, 32'h1);
    rd(BASE, 32'h0, "drained_status");
    wr(CTRL, 32'h1);
    rd(BASE, 32'h0, "empty_pop_status");
    rd(CTRL, 32'hFFFF_FFFF, "empty_pop_data");

    addressVirt = BASE + 32'd8;
    expect_chk(2'd1, 32'h0, "unsel_sel");
    rd(BASE + 32'd8, 32'h0, "unsel_data");
    addressVirt = CTRL;
    expect_chk(2'd1, 32'h1, "sel_ctrl");

    keys = 16'(1) << 6;
    wait_cyc(64);
    rd(BASE, 32'h11, "premid_status");
    wait_cyc(7);
    rst  = 1'b0;
    keys = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    expect_chk(2'd2, 32'hE, "midreset_rows");
    rd(BASE, 32'h0, "midreset_status");
    rd(CTRL, 32'hFFFF_FFFF, "midreset_data");
    wait_cyc(64);
    rd(BASE, 32'h0, "post_reset_idle");

`ifdef KEYPAD_IRQ_EN
    wr(CTRL, 32'h4);
    rd(BASE, 32'h100, "irq_en_status");
    expect_chk(2'd3, 32'h0, "irq_low_empty");
    keys = 16'(1) << 6;
    wait_cyc(64);
    rd(BASE, 32'h111, "irq_key_status");
    expect_chk(2'd3, 32'h1, "irq_high");
    keys = '0;
    wait_cyc(40);
    wr(CTRL, 32'h5);
    expect_chk(2'd3, 32'h1, "irq_lag");
    expect_chk(2'd3, 32'h0, "irq_fall");
`endif

    wait_cyc(2);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d unchecked entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_responder.md
# keypad_responder

Memory-mapped 4x4 keypad peripheral: the responder end of the CPU's virtual data bus (address / write data / write enable / read data). Drives keypad rows, samples columns, debounces, and queues key codes in a small FIFO. The CPU reads status and key codes and pops entries by register write. Instantiated inside the integrated memory block beside RAM and the hex display registers.

## Interface
- BASE_ADDR, 32'hFFFF_0010: byte address of STATUS; DATA/CTRL sits at BASE_ADDR+4.
- SCAN_DIV, 50000: clock cycles each row is held active (1 ms at 50 MHz); must be ≥ 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required before a key is accepted; must be ≥ 1.
- FIFO_DEPTH, 4: key-code entries; power of two, ≥ 2.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-low reset.
- addressVirt  in  32  bus byte address.
- dataInVirt  in  32  bus write data.
- wEnVirt  in  1  bus write enable, sampled on posedge clk.
- dataOutVirt  out  32  read data, combinational from address; 0 when not selected.
- selVirt  out  1  high when addressVirt[31:3] == BASE_ADDR[31:3].
- rows  out  4  keypad row drive, active-low, one-hot-low.
- cols  in  4  keypad column sense, active-low (pulled up externally).
- irq  out  1  present only with KEYPAD_IRQ_EN.

## Operation
- Register map (addressVirt[2] selects, [1:0] ignored):
  - STATUS, read: bit0 = not empty, bit1 = overflow (sticky), bits[7:4] = FIFO count, bit8 = irq enable (0 without macro), others 0.
  - DATA, read: {28'b0, head code}; 32'hFFFF_FFFF when FIFO empty. Reads are non-destructive.
  - CTRL, write at BASE+4: bit0 = pop head, bit1 = clear overflow, bit2 = irq enable (ignored without macro). Writes to STATUS are ignored.
- cols pass through a 2-flop synchronizer before use.
- Scanner: row index r cycles 0→1→2→3→0; rows = ~(4'b0001 << r). A per-row counter counts 0..SCAN_DIV-1. On the last count of a row, the synchronized cols are sampled into that row's slot of the scan image.
- After row 3 is sampled, the scan is complete and classified as:
  - none: no column low;
  - single: exactly one key, code = r*4 + c, where c is the low column index;
  - multi: two or more keys, treated as none.
- Debounce FSM: IDLE → CANDIDATE → PRESSED.
  - IDLE: on a single scan, latch the code, set stable count to 1, go to CANDIDATE.
  - CANDIDATE: if the same code is seen, increment stable count. When the count reaches DEBOUNCE_SCANS, push the code and go to PRESSED. A different code restarts CANDIDATE with count 1; none or multi returns to IDLE.
  - PRESSED: stay until a none scan, then go to IDLE. There is no autorepeat; a held key pushes once.
  - With DEBOUNCE_SCANS = 1, the push occurs on the first single scan (IDLE → PRESSED).
- FIFO rules:
  - Push when full: code dropped, overflow set.
  - Push and pop in the same cycle: both occur; when full, the push is accepted.
  - Pop when empty: ignored.
  - Clear-overflow together with an overflowing push: overflow ends set.

## Timing
- Reset values: rows = 4'b1110, r = 0, counters 0, FSM IDLE, FIFO empty, overflow 0, irq enable 0, irq 0. dataOutVirt follows the reset register values.
- Read latency is zero: dataOutVirt is valid in the same cycle as addressVirt.
- Writes take effect at the posedge where wEnVirt = 1 and selVirt = 1 and addressVirt[2] = 1.
- Sample for row r occurs SCAN_DIV-1 cycles after rows selects r. Full scan period = 4*SCAN_DIV cycles.
- Push is visible in STATUS the cycle after the completing sample. Worst case from stable press to push is (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 2 cycles.
- Reset asserted mid-scan or mid-debounce returns everything to reset values on that edge; pending candidates are lost.

## Configuration
- KEYPAD_IRQ_EN defined: irq port exists. irq is registered: irq = irq_enable & not-empty, updated every cycle. CTRL bit2 and STATUS bit8 are live.
- KEYPAD_IRQ_EN undefined: no irq port and no enable flop. CTRL bit2 is ignored; STATUS bit8 reads 0.

## Structure
- keypad_pkg holds:
  - register offsets (STATUS_OFS = 0, DATA_OFS = 4);
  - STATUS/CTRL bit positions;
  - EMPTY_READ = 32'hFFFF_FFFF;
  - the debounce state enum.
- Sub-module keypad_fifo: synchronous FIFO with push, pop, full, empty, count and head outputs, plus simultaneous push/pop on full. Scanner, debounce and bus decode stay in the top module.

## Test plan
- SCAN_DIV = 4, DEBOUNCE_SCANS = 2. Hold row 1 / col 2 low (key 6) → exactly one push of code 6; STATUS = 0x11; DATA = 0x6; no second push while held.
- Single-scan glitch on key 3, then release → no push; STATUS = 0; DATA = 0xFFFF_FFFF.
- Press keys 0 and 5 simultaneously → no push; release, then press key 9 → code 9 queued.
- Push 5 keys with FIFO_DEPTH = 4 → count 4, overflow = 1, DATA = first code. Write CTRL = 0x3 → count 3, overflow 0.
- Address BASE_ADDR+8 → selVirt = 0, dataOutVirt = 0. Write CTRL pop while empty → state unchanged. Reset mid-scan → rows = 4'b1110, FIFO empty.
- With KEYPAD_IRQ_EN: write CTRL = 0x4, queue one key → irq rises the cycle after push; pop → irq falls the cycle after the write.
